// File: rtl/fact_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fact_pkg
// Description : Shared FSM state type and default sizing for the factorial unit.
// Revision    : 1.0 - initial release
// ============================================================================
package fact_pkg;

    localparam int c_default_width = 32;
    localparam int c_default_n_max = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : fact_pkg
`default_nettype wire

// File: rtl/fact_dp.sv
`default_nettype none
// ============================================================================
// Module      : fact_dp
// Description : Factorial datapath: down-counter, product register, multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module fact_dp #(
    parameter int WIDTH = fact_pkg::c_default_width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_clear,
    input  logic [3:0]       i_n,
    output logic [3:0]       o_cnt,
    output logic [WIDTH-1:0] o_prod
);

    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_prod;
    logic [WIDTH-1:0] w_mul;

    // Product is kept modulo 2^WIDTH; no overflow detection.
    assign w_mul = r_prod * {{(WIDTH-4){1'b0}}, r_cnt};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt  <= 4'd0;
            r_prod <= '0;
        end else if (i_clear) begin
            r_cnt  <= 4'd0;
            r_prod <= '0;
        end else if (i_load) begin
            r_cnt  <= i_n;
            r_prod <= WIDTH'(1);
        end else if (i_step) begin
            r_cnt  <= r_cnt - 4'd1;
            r_prod <= w_mul;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_prod = r_prod;

endmodule : fact_dp
`default_nettype wire

// File: rtl/fact_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fact_ctrl
// Description : Iterative n! engine with go/busy/done handshake and range error.
// Revision    : 1.0 - initial release
// ============================================================================
module fact_ctrl #(
    parameter int WIDTH = fact_pkg::c_default_width,
    parameter int N_MAX = fact_pkg::c_default_n_max
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [3:0]       n,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);
    import fact_pkg::*;

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [3:0]       w_cnt;
    logic [WIDTH-1:0] w_prod;
    logic             w_accept;
    logic             w_bad;
    logic             w_load;
    logic             w_clear;
    logic             w_step;
    logic             w_last;

    assign w_accept = go && (r_state != ST_RUN);
    assign w_bad    = 32'(n) > 32'(N_MAX);
    assign w_load   = w_accept && !w_bad;
    assign w_clear  = w_accept && w_bad;
    assign w_last   = (w_cnt <= 4'd1);
    assign w_step   = (r_state == ST_RUN) && !w_last;

    fact_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_step  (w_step),
        .i_clear (w_clear),
        .i_n     (n),
        .o_cnt   (w_cnt),
        .o_prod  (w_prod)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        if (w_bad) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                            r_err   <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign err    = r_err;
    assign result = (r_done && !r_err) ? w_prod : '0;

endmodule : fact_ctrl
`default_nettype wire

// File: tb/tb_fact_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fact_ctrl
// Description : Self-checking bench for fact_ctrl (latency/result model + directed ops).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fact_ctrl;

    localparam int WIDTH = 32;
    localparam int N_MAX = 12;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             go  = 1'b0;
    logic [3:0]       n   = 4'd0;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fact_ctrl #(
        .WIDTH (WIDTH),
        .N_MAX (N_MAX)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .go     (go),
        .n      (n),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .result (result)
    );

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] fact(input int k);
        logic [WIDTH-1:0] p;
        p = WIDTH'(1);
        for (int i = 2; i <= k; i++) p = p * WIDTH'(i);
        return p;
    endfunction

    // Model: an accepted operation finishes max(n,1)+1 edges after the go edge
    // (1 edge for an out-of-range operand) and then holds n! until the next go.
    int               m_phase = 0;   // 0 idle, 1 computing, 2 holding result
    int               m_left  = 0;
    logic [WIDTH-1:0] m_res   = '0;
    logic             m_err   = 1'b0;
    bit               m_live  = 1'b0;

    always @(posedge clk) begin
        m_live <= 1'b1;
        if (!rst) begin
            m_phase <= 0;
            m_res   <= '0;
            m_err   <= 1'b0;
        end else if (m_phase != 1 && go) begin
            if (int'(n) > N_MAX) begin
                m_phase <= 2;
                m_err   <= 1'b1;
                m_res   <= '0;
            end else begin
                m_phase <= 1;
                m_left  <= (n == 4'd0) ? 1 : int'(n);
                m_res   <= fact(int'(n));
                m_err   <= 1'b0;
            end
        end else if (m_phase == 1) begin
            if (m_left == 1) m_phase <= 2;
            m_left <= m_left - 1;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("busy", WIDTH'(busy), WIDTH'(m_phase == 1));
            check("done", WIDTH'(done), WIDTH'(m_phase == 2));
            check("err", WIDTH'(err), WIDTH'(m_phase == 2 && m_err));
            check("result", result, (m_phase == 2 && !m_err) ? m_res : '0);
        end
    end

    task automatic run_op(input logic [3:0] nv, input int exp_lat, input logic [WIDTH-1:0] exp_res,
                          input logic exp_err, input bit inj, input string tag);
        int edges;
        @(negedge clk);
        go = 1'b1;
        n  = nv;
        @(posedge clk);
        edges = 1;
        #1;
        go = 1'b0;
        while (!done && edges < 40) begin
            go = inj && (edges == 3);
            if (inj && edges == 3) n = 4'd3;
            @(posedge clk);
            edges++;
            #1;
            go = 1'b0;
        end
        check({tag, " latency"}, WIDTH'(edges), WIDTH'(exp_lat));
        check({tag, " done"}, WIDTH'(done), WIDTH'(1));
        check({tag, " result"}, result, exp_res);
        check({tag, " err"}, WIDTH'(err), WIDTH'(exp_err));
    endtask

    initial begin
        int dones;
        logic prev;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", WIDTH'(busy), '0);
        check("reset done", WIDTH'(done), '0);
        check("reset err", WIDTH'(err), '0);
        check("reset result", result, '0);
        @(negedge clk);
        rst = 1'b1;

        run_op(4'd5,  6,  32'd120,        1'b0, 1'b0, "n5");
        run_op(4'd0,  2,  32'd1,          1'b0, 1'b0, "n0");
        run_op(4'd1,  2,  32'd1,          1'b0, 1'b0, "n1");
        run_op(4'd12, 13, 32'h1C8CFC00,   1'b0, 1'b0, "n12");
        run_op(4'd13, 1,  32'd0,          1'b1, 1'b0, "n13");
        run_op(4'd15, 1,  32'd0,          1'b1, 1'b0, "n15");
        run_op(4'd7,  8,  32'd5040,       1'b0, 1'b1, "n7 go-in-run");

        // Abort a running n=10 with reset sampled on the 4th edge.
        @(negedge clk);
        go = 1'b1;
        n  = 4'd10;
        @(posedge clk);
        #1;
        go = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort busy", WIDTH'(busy), '0);
        check("abort done", WIDTH'(done), '0);
        check("abort result", result, '0);
        rst = 1'b1;
        run_op(4'd4, 5, 32'd24, 1'b0, 1'b0, "n4 after abort");

        // go held high: each operation is 3 RUN cycles plus 1 DONE cycle.
        @(negedge clk);
        go    = 1'b1;
        n     = 4'd3;
        dones = 0;
        prev  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                check("held result", result, 32'd6);
                check("held done single", WIDTH'(prev), '0);
            end
            prev = done;
        end
        go = 1'b0;
        check("held done count", WIDTH'(dones), WIDTH'(3));

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_fact_ctrl
`default_nettype wire
